// File: rtl/siggen_seq_pkg.sv
// Purpose: shared types and constants for the trigger sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package siggen_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    WINDOW = 2'd2
  } state_t;

  // Bit positions inside the host control word
  localparam int CTRL_ARM = 0;
  localparam int CTRL_CLR = 1;

  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_TS_W       = 32;
  localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/siggen_trig_sequencer_ts_fifo.sv
// Purpose: synchronous first-word-fall-through FIFO holding trigger timestamps.
// Latency: a write is visible on dout the cycle after it is accepted.
// Backpressure: none upstream; a write while full is dropped unless a read happens in the same cycle.
// Ports: clki/rst clock and sync reset; clr empties the FIFO and beats any same-cycle write;
//        wr_en/din push; rd_en pops the head; dout is the head, valid while !empty; full/empty status.
module ts_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic         clki,
  input  logic         rst,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [W-1:0] din,
  input  logic         rd_en,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  // Extra MSB on each pointer tells a full FIFO apart from an empty one
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_wr;
  logic         do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en & ~empty & ~clr;
  // A pop frees the slot in the same cycle, so a full FIFO still takes a simultaneous push
  assign do_wr = wr_en & ~clr & (~full | do_rd);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clki) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clki) begin
    if (do_wr && !rst) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/siggen_trig_sequencer.sv
// Purpose: turns each armed trigger rising edge into a delayed acquisition window, timestamps edges, counts them.
// Latency: edge sampled at clock k -> acq_window from cycle k+1+delay for width cycles; all outputs registered.
// Backpressure: none on trig_in; timestamp pushes into a full FIFO are dropped and flagged in ts_overflow.
// Ports: clki/rst clock and sync reset; trig_in trigger; ep_ctrl bit0 arm, bit1 clear; ep_delay/ep_width window timing;
//        acq_window/acq_start/busy sequencer outputs; trig_count/missed_count counters; ts_* timestamp FIFO readout.
module siggen_trig_sequencer
  import siggen_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TS_W       = DEF_TS_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clki,
  input  logic             rst,
  input  logic             trig_in,
  input  logic [31:0]      ep_ctrl,
  input  logic [TS_W-1:0]  ep_delay,
  input  logic [TS_W-1:0]  ep_width,
  output logic             acq_window,
  output logic             acq_start,
  output logic             busy,
  output logic [CNT_W-1:0] trig_count,
  output logic [CNT_W-1:0] missed_count,
  output logic [TS_W-1:0]  ts_dout,
  output logic             ts_empty,
  output logic             ts_full,
  input  logic             ts_rd_en,
  output logic             ts_overflow
);

  localparam logic [TS_W-1:0]  TS_ONE  = TS_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t          state;
  logic            trig_d;
  logic            armed;
  logic [TS_W-1:0] timestamp;
  logic [TS_W-1:0] dly_r;
  logic [TS_W-1:0] wid_r;
  logic [TS_W-1:0] cnt;

  logic arm_lvl;
  logic clr;
  logic rise;
  logic live;
  logic take;
  logic accept;
  logic miss;
  logic push;
  logic unused_ctrl;

  assign arm_lvl     = ep_ctrl[CTRL_ARM];
  assign clr         = ep_ctrl[CTRL_CLR];
  assign unused_ctrl = ^ep_ctrl[31:2];
  assign rise        = trig_in & ~trig_d;
  // Disarm takes priority in the cycle the arm level drops, so no edge is accepted then
  assign live        = armed & arm_lvl;
  assign take        = live & rise;
  assign accept      = take & (state == IDLE);
  assign miss        = take & (state != IDLE);
  assign push        = take & ~clr;

  always_ff @(posedge clki) begin
    if (rst) begin
      state        <= IDLE;
      trig_d       <= 1'b0;
      armed        <= 1'b0;
      timestamp    <= '0;
      dly_r        <= '0;
      wid_r        <= '0;
      cnt          <= '0;
      acq_window   <= 1'b0;
      acq_start    <= 1'b0;
      busy         <= 1'b0;
      trig_count   <= '0;
      missed_count <= '0;
      ts_overflow  <= 1'b0;
    end else begin
      trig_d    <= trig_in;
      armed     <= arm_lvl;
      acq_start <= 1'b0;

      // Delay/width only change on an arm rising transition
      if (arm_lvl && !armed) begin
        timestamp <= '0;
        dly_r     <= ep_delay;
        wid_r     <= ep_width;
      end else if (armed) begin
        timestamp <= timestamp + TS_ONE;
      end

      if (!live) begin
        state      <= IDLE;
        cnt        <= '0;
        acq_window <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              cnt <= '0;
              if (dly_r != '0) begin
                state <= DELAY;
                busy  <= 1'b1;
              end else if (wid_r != '0) begin
                state      <= WINDOW;
                acq_window <= 1'b1;
                acq_start  <= 1'b1;
                busy       <= 1'b1;
              end
            end
          end
          DELAY: begin
            if (cnt == dly_r - TS_ONE) begin
              cnt <= '0;
              if (wid_r != '0) begin
                state      <= WINDOW;
                acq_window <= 1'b1;
                acq_start  <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              cnt <= cnt + TS_ONE;
            end
          end
          WINDOW: begin
            if (cnt == wid_r - TS_ONE) begin
              cnt        <= '0;
              state      <= IDLE;
              acq_window <= 1'b0;
              busy       <= 1'b0;
            end else begin
              cnt <= cnt + TS_ONE;
            end
          end
          default: begin
            state      <= IDLE;
            cnt        <= '0;
            acq_window <= 1'b0;
            busy       <= 1'b0;
          end
        endcase
      end

      if (clr) begin
        trig_count   <= '0;
        missed_count <= '0;
        ts_overflow  <= 1'b0;
      end else begin
        if (accept && trig_count != '1)   trig_count   <= trig_count + CNT_ONE;
        if (miss && missed_count != '1)   missed_count <= missed_count + CNT_ONE;
        if (push && ts_full && !ts_rd_en) ts_overflow  <= 1'b1;
      end
    end
  end

  ts_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (TS_W)
  ) u_ts_fifo (
    .clki  (clki),
    .rst   (rst),
    .clr   (clr),
    .wr_en (push),
    .din   (timestamp),
    .rd_en (ts_rd_en),
    .dout  (ts_dout),
    .empty (ts_empty),
    .full  (ts_full)
  );

endmodule

// File: doc/siggen_trig_sequencer.md
Name: siggen_trig_sequencer

Overview:
- Downstream consumer of the 40 Hz signal-generator trigger.
- Detects each rising edge of the trigger and, after a host-programmed delay, opens an acquisition window of host-programmed width.
- Timestamps every armed trigger edge into a small FIFO for host readout, and keeps accepted, missed and overflow counts.
- Sits between the trigger generator and the acquisition/readout logic; control comes from host endpoint wires.

Parameters:
- FIFO_DEPTH, 16, timestamp FIFO entries; must be a power of 2.
- TS_W, 32, timestamp and counter width.
- CNT_W, 16, width of the trigger and missed counters.

Ports:
- clki, in, 1, system clock (100 MHz).
- rst, in, 1, synchronous active-high reset.
- trig_in, in, 1, trigger from the generator; synchronous to clki.
- ep_ctrl, in, 32, host control:
  - bit0 arm, level.
  - bit1 clear, level; acts on each cycle it is high.
  - other bits ignored.
- ep_delay, in, TS_W, edge-to-window delay in clki cycles.
- ep_width, in, TS_W, window length in clki cycles.
- acq_window, out, 1, acquisition window.
- acq_start, out, 1, one-cycle pulse on the first window cycle.
- busy, out, 1, high in DELAY or WINDOW.
- trig_count, out, CNT_W, edges that started a window.
- missed_count, out, CNT_W, armed edges that arrived while busy.
- ts_dout, out, TS_W, FIFO head; first-word fall-through.
- ts_empty, out, 1, FIFO empty.
- ts_full, out, 1, FIFO full.
- ts_rd_en, in, 1, pop the FIFO head.
- ts_overflow, out, 1, sticky flag: a push was dropped.

Behaviour:
- Reset values:
  - acq_window, acq_start, busy, ts_full, ts_overflow = 0.
  - trig_count, missed_count, timestamp, FIFO pointers = 0.
  - ts_empty = 1; state = IDLE.
  - trig_d (previous trig_in) = 0.
- Edge detection: rise = trig_in & ~trig_d, evaluated at edge k; trig_d <= trig_in every cycle.
- Arm handling:
  - armed = ep_ctrl[0], registered.
  - On an armed 0->1 transition: timestamp <= 0, and ep_delay/ep_width are latched into dly_r/wid_r.
  - While armed, timestamp increments every cycle and wraps modulo 2^TS_W.
  - Edges are ignored while unarmed.
- States:
  - IDLE: armed & rise -> DELAY with cnt=0 if dly_r>0; -> WINDOW if dly_r==0 and wid_r>0; stay IDLE if dly_r==0 and wid_r==0 (the edge still counts).
  - DELAY: cnt increments; on cnt==dly_r-1 -> WINDOW (or -> IDLE if wid_r==0), cnt <= 0.
  - WINDOW: acq_window=1; cnt increments; on cnt==wid_r-1 -> IDLE.
- Timing:
  - Rise sampled at edge k gives acq_window high from cycle k+1+dly_r for exactly wid_r cycles.
  - acq_start is high in the first of those cycles only.
  - Outputs are registered; there is no combinational path from trig_in.
- Counting:
  - Rise accepted in IDLE: trig_count+1.
  - Rise while busy: missed_count+1, no retrigger.
  - Both counters saturate at all-ones.
- FIFO push and pop:
  - Every armed rise pushes the current timestamp, whether accepted or missed.
  - Push when full without a same-cycle pop: dropped, ts_overflow <= 1.
  - Push and pop in the same cycle when full: both succeed, count unchanged.
  - Pop when empty is ignored.
  - ts_dout is valid whenever !ts_empty.
- Disarm mid-operation (arm 1->0): state -> IDLE, acq_window and busy drop on the next cycle, a pending acq_start is suppressed. FIFO contents and counts are kept.
- Clear (ep_ctrl[1]=1):
  - Zeroes trig_count, missed_count, ts_overflow and the FIFO pointers.
  - Does not affect state or timestamp.
  - A push in the same cycle is discarded; clear wins.
- Reset mid-window: all outputs return to their reset values on the next clock edge.
- Changing ep_delay/ep_width while armed has no effect until the next arm rising transition.

Decomposition:
- Package siggen_seq_pkg holds:
  - state enum IDLE/DELAY/WINDOW;
  - ctrl bit indices CTRL_ARM=0, CTRL_CLR=1;
  - default widths.
- Sub-module ts_fifo:
  - synchronous FWFT FIFO with parameters DEPTH and W;
  - ports clki, rst, clr, wr_en, din, rd_en, dout, empty, full;
  - pointers one bit wider than the address, for full/empty detection.

Test Plan:
- Reset, then arm with delay=10, width=5, one trig_in rise at edge k -> acq_window high cycles k+11..k+15, acq_start at k+11, trig_count=1, one FIFO entry equal to the timestamp at edge k.
- delay=0, width=1 -> acq_window high only at cycle k+1. delay=0, width=0 -> no window, trig_count=1.
- Second rise 3 cycles after the first, with delay=10 and width=5 -> missed_count=1, trig_count=1, two FIFO entries differing by 3.
- 17 armed rises with no pops, depth 16 -> ts_full=1 after the 16th, ts_overflow=1 after the 17th, and 16 pops return strictly increasing timestamps. Then assert clear -> ts_empty=1, ts_overflow=0, counts 0.
- Disarm during WINDOW -> acq_window=0 and busy=0 on the next cycle, counts kept. Re-arm -> timestamp restarts at 0 and the new ep_delay takes effect.
- Assert rst in DELAY -> all outputs at reset values the next cycle. A subsequent rise while unarmed -> no window, no count, no push.
